instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the instruction memory port.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF, encoding of the halt instruction (used only with FETCH_HALT_EN).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Addr  output  ADDR_W  word address driven to instructionmemory; equals the PC register, combinationally.
REQ-006 Instruction  input  32  word returned by instructionmemory, valid in the same cycle as Addr.
REQ-007 ready_in  input  1  decode stage accepts instr_out this cycle.
REQ-008 branch_en  input  1  taken branch this cycle.
REQ-009 branch_off  input  16  signed word offset, relative to pc_out.
REQ-010 jump_en  input  1  jump this cycle.
REQ-011 jump_target  input  26  jump field; bits [ADDR_W-1:0] used.
REQ-012 instr_out  output  32  IF/ID instruction register.
REQ-013 pc_out  output  ADDR_W  IF/ID register, address of instr_out plus 1.
REQ-014 valid_out  output  1  instr_out/pc_out hold a live instruction.
REQ-015 halted  output  1  fetch stopped by halt instruction.

Function
REQ-016 The unit SHALL advance when (valid_out==0 or ready_in==1) and no redirect and state is RUN: instr_out<=Instruction, pc_out<=PC+1, valid_out<=1, PC<=PC+1.
REQ-017 When not advancing and no redirect (stall), PC, instr_out, pc_out, valid_out SHALL hold.
REQ-018 Redirect SHALL take priority over stall: PC<=target, valid_out<=0, instr_out and pc_out hold.
REQ-019 jump_en SHALL take priority over branch_en; jump target = jump_target[ADDR_W-1:0].
REQ-020 Branch target SHALL be pc_out + branch_off truncated to ADDR_W bits (modulo 2^ADDR_W).
REQ-021 PC+1 SHALL wrap from 2^ADDR_W-1 to 0 without any flag.
REQ-022 Fetch latency: instruction at Addr A SHALL appear on instr_out one cycle after A is driven and advance holds.
REQ-023 FSM states RUN and HALT; RUN->HALT when an advance latches Instruction==HALT_WORD; HALT->RUN only by rst.
REQ-024 In HALT: PC frozen, redirects ignored, no new latch; valid_out SHALL clear on the first cycle with ready_in==1, then stay 0.
REQ-025 halted SHALL equal (state==HALT).

Reset
REQ-026 On rst==1 at a clock edge: PC=0, instr_out=0, pc_out=0, valid_out=0, state=RUN, halted=0; rst overrides all other inputs, including mid-stall or in HALT.
REQ-027 First cycle after reset release SHALL drive Addr=0 and fetch it if ready_in or valid_out==0.

Configuration
REQ-028 Macro FETCH_HALT_EN: defined -> REQ-023/024 halt detection active; undefined -> state stays RUN, halted tied 0, HALT_WORD ignored.

Structure
REQ-029 Shared package mips_pkg SHALL hold ADDR_W default, HALT_WORD default, and the fetch state enum (RUN, HALT).
REQ-030 Single module; no sub-module; PC next-value mux and IF/ID register in the same file.

Verification
REQ-031 Reset then ready_in=1 for 4 cycles with memory words 0..3 -> Addr 0,1,2,3; instr_out = words 0..3 one cycle later; pc_out 1,2,3,4; valid_out=1 from cycle 2.
REQ-032 ready_in=0 for 3 cycles with valid_out=1 at PC=5 -> Addr stays 5, instr_out/pc_out unchanged; resume -> word 5 latched next edge.
REQ-033 pc_out=8, branch_en=1, branch_off=-3 during stall -> next Addr=5, valid_out=0 one cycle, then word 5 with pc_out=6.
REQ-034 branch_en=1 and jump_en=1, jump_target=26'h0000020 -> Addr=32; PC at 1023 advancing -> Addr=0.
REQ-035 FETCH_HALT_EN defined, word 3 = 32'hFFFFFFFF -> instr_out=HALT_WORD valid, halted=1, Addr frozen at 4, valid_out drops after ready_in, jump ignored; rst -> Addr=0, halted=0.
REQ-036 rst asserted mid-stall with valid_out=1 -> next edge all outputs 0, Addr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch address width, halt encoding and fetch FSM states.
package mips_pkg;

  localparam int          MIPS_ADDR_W    = 10;
  localparam logic [31:0] MIPS_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// PC + IF/ID register: 1-cycle fetch latency, holds while ready_in is low, redirects override stalls.
// FETCH_HALT_EN enables halt-instruction detection; otherwise fetch never leaves RUN.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = MIPS_ADDR_W,
  parameter logic [31:0] HALT_WORD = MIPS_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Instruction,
  input  logic              ready_in,
  input  logic              branch_en,
  input  logic [15:0]       branch_off,
  input  logic              jump_en,
  input  logic [25:0]       jump_target,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              halted
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       br_sum;
  logic              run;
  logic              redirect;
  logic              advance;
  logic              halt_hit;
  logic              unused_bits;
  fetch_state_t      state;

  assign Addr   = pc;
  assign pc_inc = pc + ADDR_W'(1);

  // Branch offset is relative to pc_out (address of the instruction in IF/ID plus 1).
  assign br_sum = 32'(pc_out) + {{16{branch_off[15]}}, branch_off};
  assign target = jump_en ? jump_target[ADDR_W-1:0] : br_sum[ADDR_W-1:0];

  assign run      = (state == RUN);
  assign redirect = run & (jump_en | branch_en);
  assign advance  = run & ~(jump_en | branch_en) & (~valid_out | ready_in);
  assign halt_hit = (Instruction == HALT_WORD);
  assign halted   = (state == HALT);

  assign unused_bits = ^{jump_target, br_sum, halt_hit};

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (advance && halt_hit) begin
      state <= HALT;
    end
  end
`else
  assign state = RUN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (!run) begin
      // Halted: drain the last live instruction once decode takes it.
      if (ready_in) begin
        valid_out <= 1'b0;
      end
    end else if (redirect) begin
      pc        <= target;
      valid_out <= 1'b0;
    end else if (advance) begin
      instr_out <= Instruction;
      pc_out    <= pc_inc;
      valid_out <= 1'b1;
      pc        <= pc_inc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, halt corner sequence, random vs model.
module tb_instruction_fetch;

  localparam int DEPTH = 1024;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic [31:0] instruction;
  logic        ready_in;
  logic        branch_en;
  logic [15:0] branch_off;
  logic        jump_en;
  logic [25:0] jump_target;
  logic [31:0] instr_out;
  logic [9:0]  pc_out;
  logic        valid_out;
  logic        halted;

  logic [31:0] mem [DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  int          m_pc, m_pcout;
  logic [31:0] m_instr;
  logic        m_valid, m_halt;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        br;
    logic [15:0] off;
    logic        jen;
    logic [25:0] jt;
    logic [9:0]  e_addr;
    logic [31:0] e_instr;
    logic [9:0]  e_pcout;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign instruction = mem[addr];

  instruction_fetch #(.ADDR_W(10), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .rst(rst), .Addr(addr), .Instruction(instruction),
    .ready_in(ready_in), .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .jump_target(jump_target), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out), .halted(halted)
  );

  function automatic logic [31:0] w(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic r, rdy, br, input logic [15:0] off,
                              input logic jen, input logic [25:0] jt,
                              input int ea, input logic [31:0] ei, input int ep, input logic ev);
    vec_t v;
    v.r = r; v.rdy = rdy; v.br = br; v.off = off; v.jen = jen; v.jt = jt;
    v.e_addr = 10'(ea); v.e_instr = ei; v.e_pcout = 10'(ep); v.e_valid = ev;
    return v;
  endfunction

  // Reference model: the fetch rules applied to plain integers at each rising edge.
  function automatic void model_step();
    if (rst) begin
      m_pc = 0; m_instr = '0; m_pcout = 0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      if (ready_in) m_valid = 1'b0;
    end else if (jump_en) begin
      m_pc = int'(jump_target) % DEPTH;
      m_valid = 1'b0;
    end else if (branch_en) begin
      m_pc = ((m_pcout + int'($signed(branch_off))) % DEPTH + DEPTH) % DEPTH;
      m_valid = 1'b0;
    end else if (!m_valid || ready_in) begin
      m_instr = mem[m_pc];
      m_pcout = (m_pc + 1) % DEPTH;
      m_valid = 1'b1;
      m_pc    = m_pcout;
`ifdef FETCH_HALT_EN
      if (m_instr == HALT_W) m_halt = 1'b1;
`endif
    end
  endfunction

  task automatic cycle(input logic r, rdy, br, input logic [15:0] off,
                       input logic jen, input logic [25:0] jt);
    rst = r; ready_in = rdy; branch_en = br; branch_off = off;
    jump_en = jen; jump_target = jt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [9:0] ea, input logic [31:0] ei,
                           input logic [9:0] ep, input logic ev, input logic eh);
    check({tag, " Addr"},      32'(addr),      32'(ea));
    check({tag, " instr_out"}, instr_out,      ei);
    check({tag, " pc_out"},    32'(pc_out),    32'(ep));
    check({tag, " valid_out"}, 32'(valid_out), 32'(ev));
    check({tag, " halted"},    32'(halted),    32'(eh));
  endtask

  initial begin
    rst = 1'b1; ready_in = 1'b0; branch_en = 1'b0; branch_off = '0;
    jump_en = 1'b0; jump_target = '0;
    m_pc = 0; m_pcout = 0; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = w(i);

    // rst rdy br off jen jt -> Addr instr pc_out valid
    vecs.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,       0,    32'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       1,    w(0),   1, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       2,    w(1),   2, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       3,    w(2),   3, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       4,    w(3),   4, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       5,    w(4),   5, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       5,    w(4),   5, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       5,    w(4),   5, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       5,    w(4),   5, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       6,    w(5),   6, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       7,    w(6),   7, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       8,    w(7),   8, 1));
    vecs.push_back(mk(0, 0, 1, 16'hFFFD, 0, 26'h0,       5,    w(7),   8, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       6,    w(5),   6, 1));
    vecs.push_back(mk(0, 1, 1, 16'd100,  1, 26'h20,      32,   w(5),   6, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0,    1, 26'h3FF,     1023, w(5),   6, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,       0,    w(1023), 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       0,    w(1023), 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,       0,    32'h0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       1,    w(0),   1, 1));
    vecs.push_back(mk(0, 0, 1, 16'hFFFE, 0, 26'h0,       1023, w(0),   1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0,    1, 26'h3FFFC05, 5,    w(0),   1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,       6,    w(5),   6, 1));

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].rdy, vecs[i].br, vecs[i].off, vecs[i].jen, vecs[i].jt);
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr,
                vecs[i].e_pcout, vecs[i].e_valid, 1'b0);
    end

    mem[3] = HALT_W;
    cycle(1, 0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'h0, 0, 26'h0);
`ifdef FETCH_HALT_EN
    check_all("halt_enter", 10'd4, HALT_W, 10'd4, 1'b1, 1'b1);
    cycle(0, 0, 0, 16'h0, 1, 26'h20);
    check_all("halt_stall_jump", 10'd4, HALT_W, 10'd4, 1'b1, 1'b1);
    cycle(0, 1, 1, 16'h10, 0, 26'h0);
    check_all("halt_drain", 10'd4, HALT_W, 10'd4, 1'b0, 1'b1);
    cycle(0, 1, 0, 16'h0, 1, 26'h7);
    check_all("halt_hold", 10'd4, HALT_W, 10'd4, 1'b0, 1'b1);
    cycle(1, 1, 0, 16'h0, 0, 26'h0);
    check_all("halt_reset", 10'd0, 32'h0, 10'd0, 1'b0, 1'b0);
`else
    check_all("nohalt_word", 10'd4, HALT_W, 10'd4, 1'b1, 1'b0);
    cycle(0, 1, 0, 16'h0, 0, 26'h0);
    check_all("nohalt_next", 10'd5, w(4), 10'd5, 1'b1, 1'b0);
`endif
    mem[3] = w(3);

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_W) mem[i] = 32'h0;
    end
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 4; i++) mem[$urandom_range(0, DEPTH - 1)] = HALT_W;
`endif
    cycle(1, 0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), 16'($urandom),
            ($urandom_range(0, 15) == 0), 26'($urandom));
      check_all("rnd", 10'(m_pc), m_instr, 10'(m_pcout), m_valid, m_halt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
